// File: rtl/time_set_ctrl.sv
// Time-of-day keeper with a two-button set interface: BtnMode cycles RUN -> SET_HR -> SET_MIN,
// BtnInc bumps the selected field, and Blink strobes the field being edited.
module time_set_ctrl #(
    parameter int TICKS_PER_SEC = 100,
    parameter int BLINK_TICKS   = 50
) (
    input  logic       ClkIn,
    input  logic       Clr_,
    input  logic       Tick100,
    input  logic       BtnMode,
    input  logic       BtnInc,
    output logic [4:0] Hours,
    output logic [5:0] Minutes,
    output logic [5:0] Seconds,
    output logic [1:0] Mode,
    output logic       Blink,
    output logic [6:0] dbg_tick_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        BAD     = 2'b11
    } mode_e;

    localparam int              BW         = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [6:0]      TICK_LAST  = 7'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_TICKS - 1);

    mode_e         mode_q, mode_d;
    logic [4:0]    hours_q, hours_d;
    logic [5:0]    minutes_q, minutes_d;
    logic [5:0]    seconds_q, seconds_d;
    logic [6:0]    tick_cnt_q, tick_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          btn_mode_q, btn_mode_d;
    logic          btn_inc_q, btn_inc_d;

    logic          mode_press;
    logic          inc_press;

    // History resets to 1 so a button held through reset release is not seen as a press.
    assign mode_press = BtnMode & ~btn_mode_q;
    assign inc_press  = BtnInc  & ~btn_inc_q;

    always_ff @(posedge ClkIn or negedge Clr_) begin
        if (!Clr_) begin
            mode_q      <= RUN;
            hours_q     <= '0;
            minutes_q   <= '0;
            seconds_q   <= '0;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            btn_mode_q  <= 1'b1;
            btn_inc_q   <= 1'b1;
        end else begin
            mode_q      <= mode_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            btn_mode_q  <= btn_mode_d;
            btn_inc_q   <= btn_inc_d;
        end
    end

    always_comb begin
        mode_d      = mode_q;
        hours_d     = hours_q;
        minutes_d   = minutes_q;
        seconds_d   = seconds_q;
        tick_cnt_d  = tick_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        btn_mode_d  = BtnMode;
        btn_inc_d   = BtnInc;

        case (mode_q)
            RUN: begin
                blink_d     = 1'b0;
                blink_cnt_d = '0;
                // The tick is counted even when a mode press lands on the same edge.
                if (Tick100) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        if (seconds_q == 6'd59) begin
                            seconds_d = '0;
                            if (minutes_q == 6'd59) begin
                                minutes_d = '0;
                                hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                            end else begin
                                minutes_d = minutes_q + 6'd1;
                            end
                        end else begin
                            seconds_d = seconds_q + 6'd1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 7'd1;
                    end
                end
                if (mode_press) begin
                    mode_d = SET_HR;
                end
            end

            SET_HR, SET_MIN: begin
                if (Tick100) begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_d     = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BW'(1);
                    end
                end
                // A mode press wins over a coincident increment.
                if (mode_press) begin
                    blink_cnt_d = '0;
                    blink_d     = 1'b0;
                    if (mode_q == SET_HR) begin
                        mode_d = SET_MIN;
                    end else begin
                        mode_d     = RUN;
                        seconds_d  = '0;
                        tick_cnt_d = '0;
                    end
                end else if (inc_press) begin
                    if (mode_q == SET_HR) begin
                        hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                    end else begin
                        minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
                    end
                end
            end

            default: begin
                mode_d      = RUN;
                blink_d     = 1'b0;
                blink_cnt_d = '0;
            end
        endcase
    end

    assign Hours        = hours_q;
    assign Minutes      = minutes_q;
    assign Seconds      = seconds_q;
    assign Mode         = mode_q;
    assign Blink        = blink_q;
    assign dbg_tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus a random phase, every cycle compared against
// a seconds-of-day reference model.
module tb_time_set_ctrl;

    localparam int TPS   = 100;
    localparam int BLINK = 50;

    logic       ClkIn;
    logic       Clr_;
    logic       Tick100;
    logic       BtnMode;
    logic       BtnInc;
    logic [4:0] Hours;
    logic [5:0] Minutes;
    logic [5:0] Seconds;
    logic [1:0] Mode;
    logic       Blink;
    logic [6:0] dbg_tick_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: time as seconds since midnight.
    int   m_mode;
    int   m_secs;
    int   m_tick;
    int   m_bcnt;
    int   m_blink;
    logic m_pm;
    logic m_pi;

    time_set_ctrl #(.TICKS_PER_SEC(TPS), .BLINK_TICKS(BLINK)) dut (
        .ClkIn        (ClkIn),
        .Clr_         (Clr_),
        .Tick100      (Tick100),
        .BtnMode      (BtnMode),
        .BtnInc       (BtnInc),
        .Hours        (Hours),
        .Minutes      (Minutes),
        .Seconds      (Seconds),
        .Mode         (Mode),
        .Blink        (Blink),
        .dbg_tick_cnt (dbg_tick_cnt)
    );

    initial ClkIn = 1'b0;
    always #10 ClkIn = ~ClkIn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_secs  = 0;
        m_tick  = 0;
        m_bcnt  = 0;
        m_blink = 0;
        m_pm    = 1'b1;
        m_pi    = 1'b1;
    endtask

    function automatic int m_hr();
        return m_secs / 3600;
    endfunction

    function automatic int m_min();
        return (m_secs / 60) % 60;
    endfunction

    task automatic model_step(input logic m, input logic i, input logic t);
        logic mp;
        logic ip;
        int   h;
        int   mi;
        int   s;
        if (!Clr_) begin
            model_reset();
            return;
        end
        mp   = m && !m_pm;
        ip   = i && !m_pi;
        m_pm = m;
        m_pi = i;
        if (m_mode == 0) begin
            if (t) begin
                m_tick++;
                if (m_tick == TPS) begin
                    m_tick = 0;
                    m_secs = (m_secs + 1) % 86400;
                end
            end
            if (mp) begin
                m_mode  = 1;
                m_bcnt  = 0;
                m_blink = 0;
            end
        end else if (mp) begin
            m_bcnt  = 0;
            m_blink = 0;
            if (m_mode == 1) begin
                m_mode = 2;
            end else begin
                m_mode = 0;
                m_secs = m_secs - (m_secs % 60);
                m_tick = 0;
            end
        end else begin
            if (t) begin
                m_bcnt++;
                if (m_bcnt == BLINK) begin
                    m_bcnt  = 0;
                    m_blink = 1 - m_blink;
                end
            end
            if (ip) begin
                h  = m_hr();
                mi = m_min();
                s  = m_secs % 60;
                if (m_mode == 1) h = (h + 1) % 24;
                else             mi = (mi + 1) % 60;
                m_secs = h * 3600 + mi * 60 + s;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".mode"},    32'(Mode),         32'(m_mode));
        chk({tag, ".hours"},   32'(Hours),        32'(m_hr()));
        chk({tag, ".minutes"}, 32'(Minutes),      32'(m_min()));
        chk({tag, ".seconds"}, 32'(Seconds),      32'(m_secs % 60));
        chk({tag, ".blink"},   32'(Blink),        32'(m_blink));
        chk({tag, ".tick"},    32'(dbg_tick_cnt), 32'(m_tick));
    endtask

    task automatic step(input logic m, input logic i, input logic t);
        @(negedge ClkIn);
        BtnMode = m;
        BtnInc  = i;
        Tick100 = t;
        @(posedge ClkIn);
        model_step(m, i, t);
        #1;
        check_all("cycle");
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic press_mode();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_inc();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic rm;
        logic ri;
        int   hr_before;
        int   sec_before;

        Clr_    = 1'b0;
        Tick100 = 1'b0;
        BtnMode = 1'b0;
        BtnInc  = 1'b0;
        model_reset();
        #1;
        check_all("reset0");
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        Clr_ = 1'b1;

        // One second of ticks in RUN.
        tick_n(99);
        chk("r032_sec_before", 32'(Seconds), 32'd0);
        tick_n(1);
        chk("r032_sec", 32'(Seconds), 32'd1);
        chk("r032_tick", 32'(dbg_tick_cnt), 32'd0);

        // Increments ignored in RUN.
        press_inc();
        chk("run_inc_ignored", 32'(Hours), 32'd0);

        // Hours wrap through 24 to 1; minutes wrap through 60 to unchanged.
        press_mode();
        for (int k = 0; k < 25; k++) press_inc();
        chk("r034_hours", 32'(Hours), 32'd1);
        chk("r034_mode1", 32'(Mode), 32'd1);
        press_mode();
        for (int k = 0; k < 60; k++) press_inc();
        chk("r034_minutes", 32'(Minutes), 32'd0);
        chk("r034_hours2", 32'(Hours), 32'd1);
        press_mode();
        chk("r034_run", 32'(Mode), 32'd0);

        // Tick counter held at 73 through the set states, cleared on exit.
        tick_n(73);
        press_mode();
        press_mode();
        chk("r035_tick_held", 32'(dbg_tick_cnt), 32'd73);
        press_mode();
        chk("r035_mode", 32'(Mode), 32'd0);
        chk("r035_sec", 32'(Seconds), 32'd0);
        chk("r035_tick", 32'(dbg_tick_cnt), 32'd0);
        tick_n(99);
        chk("r035_sec99", 32'(Seconds), 32'd0);
        tick_n(1);
        chk("r035_sec100", 32'(Seconds), 32'd1);

        // Blink cadence and mode-over-increment priority.
        press_mode();
        chk("r036_blink0", 32'(Blink), 32'd0);
        tick_n(50);
        chk("r036_blink1", 32'(Blink), 32'd1);
        tick_n(50);
        chk("r036_blink2", 32'(Blink), 32'd0);
        hr_before = m_hr();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("r036_mode", 32'(Mode), 32'd2);
        chk("r036_hours", 32'(Hours), 32'(hr_before));
        press_mode();

        // Mode press coinciding with the second boundary tick.
        tick_n(99);
        sec_before = m_secs % 60;
        step(1'b1, 1'b0, 1'b1);
        chk("r026_mode", 32'(Mode), 32'd1);
        chk("r026_sec", 32'(Seconds), 32'((sec_before + 1) % 60));
        step(1'b0, 1'b0, 1'b0);
        press_mode();
        press_mode();

        // Preload 23:59:59 then roll over midnight.
        press_mode();
        for (int k = 0; k < 24; k++) if (m_hr() != 23) press_inc();
        press_mode();
        for (int k = 0; k < 60; k++) if (m_min() != 59) press_inc();
        press_mode();
        tick_n(59 * TPS);
        chk("r033_h", 32'(Hours), 32'd23);
        chk("r033_m", 32'(Minutes), 32'd59);
        chk("r033_s", 32'(Seconds), 32'd59);
        tick_n(TPS);
        chk("r033_h0", 32'(Hours), 32'd0);
        chk("r033_m0", 32'(Minutes), 32'd0);
        chk("r033_s0", 32'(Seconds), 32'd0);
        chk("r033_mode", 32'(Mode), 32'd0);

        // Random button/tick activity.
        rm = 1'b0;
        ri = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) rm = ~rm;
            if ($urandom_range(0, 3) == 0) ri = ~ri;
            step(rm, ri, 1'($urandom_range(0, 2) == 0));
        end

        // Reset mid-set aborts with nothing left over.
        step(1'b0, 1'b0, 1'b0);
        press_mode();
        press_inc();
        Clr_ = 1'b0;
        BtnMode = 1'b1;
        model_reset();
        #1;
        check_all("r031_async");
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        Clr_ = 1'b1;

        // Button held across reset release gives no press.
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b0);
        chk("r037_held", 32'(Mode), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("r037_press", 32'(Mode), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter: TICKS_PER_SEC, default 100, number of Tick100 pulses per second.
REQ-002 Parameter: BLINK_TICKS, default 50, number of Tick100 pulses per Blink half-period.
REQ-003 ClkIn  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-004 Clr_  input  1  reset, asynchronous, active-low.
REQ-005 Tick100  input  1  one-ClkIn-cycle pulse at 100 Hz, synchronous to ClkIn.
REQ-006 BtnMode  input  1  mode button level, already synchronized and debounced.
REQ-007 BtnInc  input  1  increment button level, already synchronized and debounced.
REQ-008 Hours  output  5  current hours, 0-23, binary.
REQ-009 Minutes  output  6  current minutes, 0-59, binary.
REQ-010 Seconds  output  6  current seconds, 0-59, binary.
REQ-011 Mode  output  2  FSM state: 00 RUN, 01 SET_HR, 10 SET_MIN; 11 unused.
REQ-012 Blink  output  1  display blank strobe for the field being set; 0 in RUN.

Function
REQ-013 Press event: BtnX==1 and its previous-cycle registered sample==0, evaluated at a rising ClkIn edge; the action takes effect at that same edge.
REQ-014 A held button produces exactly one press event; releasing it produces none.
REQ-015 FSM transitions on a BtnMode press: RUN->SET_HR, SET_HR->SET_MIN, SET_MIN->RUN; no other transitions, except reset.
REQ-016 Mode value 11, if ever reached, goes to RUN at the next edge.
REQ-017 RUN: a 7-bit tick counter increments on each Tick100; on the Tick100 where the counter equals TICKS_PER_SEC-1, it clears to 0 and Seconds advances.
REQ-018 Seconds advance: 59->0 with Minutes carry; Minutes 59->0 with Hours carry; Hours 23->0; 23:59:59 advances to 00:00:00 in a single edge.
REQ-019 SET_HR/SET_MIN: time-of-day does not advance; Tick100 drives only the blink counter.
REQ-020 SET_HR: a BtnInc press increments Hours, 23->0, with no carry into any other field.
REQ-021 SET_MIN: a BtnInc press increments Minutes, 59->0, with no carry into Hours.
REQ-022 BtnInc presses in RUN are ignored.
REQ-023 Transition SET_MIN->RUN clears Seconds and the tick counter to 0 at the same edge, so the first second after exit is a full TICKS_PER_SEC ticks.
REQ-024 Transition RUN->SET_HR keeps Hours/Minutes/Seconds; the tick counter holds its value and is cleared on exit per REQ-023.
REQ-025 Blink: 0 in RUN; a blink counter counts Tick100 in set states and Blink toggles when it reaches BLINK_TICKS-1, clearing the counter; each set-state entry loads the counter and Blink with 0.
REQ-026 Simultaneous BtnMode press and Tick100 in RUN: the mode transition occurs and the tick is still counted, so a second boundary advances Seconds at that edge.
REQ-027 Simultaneous BtnMode and BtnInc presses in a set state: the mode transition wins and the increment is discarded.
REQ-028 Outputs are registered directly; there is no combinational path from inputs to outputs.

Reset
REQ-029 Clr_=0 immediately forces Mode=00, Hours=0, Minutes=0, Seconds=0, Blink=0, the tick and blink counters to 0, and the button history registers to 1, independent of ClkIn.
REQ-030 A button held high across reset release produces no press event until it is released and pressed again.
REQ-031 Reset asserted in any state, including mid-set, aborts the operation without a partial update.

Verification
REQ-032 Release reset, apply 100 Tick100 pulses in RUN -> Seconds=1 exactly at the 100th pulse and tick counter=0.
REQ-033 Preload 23:59:59 via set mode and ticks, then apply one second of ticks -> 00:00:00, Mode=00.
REQ-034 BtnMode press, BtnInc pressed 25 times -> Hours=1, Mode=01; BtnMode press, BtnInc pressed 60 times -> Minutes unchanged, Hours=1.
REQ-035 In SET_MIN with tick counter=73, press BtnMode -> Mode=00, Seconds=0, tick counter=0; the next Seconds increment occurs after 100 more ticks.
REQ-036 In SET_HR, apply 50 ticks -> Blink=1; apply 50 more -> Blink=0; BtnMode and BtnInc pressed in the same cycle -> Mode=10 and Hours unchanged.
REQ-037 Hold BtnMode high through reset release for 10 cycles -> Mode stays 00; release the button and press it again -> Mode=01.
